pcs_scrambler_core: RTL

Parametrised self-synchronising scrambler/descrambler for the 10GBASE-R PCS implementing G(x) = 1 + x^39 + x^58 (IEEE 802.3 clause 49.2). One module serves both the TX path (encoder → gearbox) and the RX path (block-lock → decoder), selected by a parameter. Compared with the current scrambler it adds valid/ready backpressure, sync-header passthrough, runtime bypass, a synchronous flush, and a descrambler lock indication.

---
 rtl/pcs_scrambler_if.sv | 14 +
 rtl/pcs_scrambler_core.sv | 94 +++++++++
 2 files changed

// File: rtl/pcs_scrambler_if.sv
// Stream bundle for one side of the scrambler: payload word plus its 2-bit sync header.
// A word transfers on a rising edge where valid && ready; the master holds valid, data
// and hdr stable until that edge, and ready may depend combinationally on the far side.
interface pcs_scrambler_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [1:0]            hdr;

  modport master (output valid, output data, output hdr, input ready);
  modport slave  (input valid, input data, input hdr, output ready);
endinterface

// File: rtl/pcs_scrambler_core.sv
// Self-synchronising 10GBASE-R scrambler (MODE 0) / descrambler (MODE 1), G(x) = 1 + x^39 + x^58,
// with one output register stage, header passthrough, bypass, flush and a descrambler lock flag.
module pcs_scrambler_core #(
  parameter int DATA_WIDTH = 32,
  parameter int MODE       = 0
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  pcs_scrambler_if.slave  s_in,
  pcs_scrambler_if.master m_out,
  input  logic            i_bypass,
  input  logic            i_flush,
  output logic            o_locked
);

  localparam int         LOCK_WORDS = (58 + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam logic [1:0] LOCK_CNT   = LOCK_WORDS[1:0];

  logic [57:0]           lfsr_q;
  logic [57:0]           lfsr_next;
  logic [57:0]           s;
  logic [DATA_WIDTH-1:0] y;
  logic                  fb;
  logic                  acc;
  logic [1:0]            lock_cnt_q;
  logic [1:0]            cnt_next;
  logic                  lock_next;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            hdr_q;
  logic                  locked_q;

  assign s_in.ready  = !valid_q || m_out.ready;
  assign acc         = s_in.valid && s_in.ready;
  assign m_out.valid = valid_q;
  assign m_out.data  = data_q;
  assign m_out.hdr   = hdr_q;
  assign o_locked    = locked_q;

  // Bit-serial LFSR unrolled across the word; a flush in the same cycle seeds it with all ones.
  always_comb begin
    s  = i_flush ? '1 : lfsr_q;
    y  = '0;
    fb = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb   = s[38] ^ s[57];
      y[i] = s_in.data[i] ^ fb;
      s    = {s[56:0], (MODE == 1) ? s_in.data[i] : y[i]};
    end
    lfsr_next = s;
  end

  always_comb begin
    cnt_next = i_flush ? 2'd0 : lock_cnt_q;
    if (acc && (cnt_next != LOCK_CNT)) begin
      cnt_next = cnt_next + 2'd1;
    end
    if (i_flush) begin
      lock_next = 1'b0;
    end else if (MODE == 1) begin
      lock_next = (cnt_next == LOCK_CNT);
    end else begin
      lock_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lfsr_q     <= '1;
      valid_q    <= 1'b0;
      data_q     <= '0;
      hdr_q      <= 2'b00;
      locked_q   <= 1'b0;
      lock_cnt_q <= 2'd0;
    end else begin
      if (acc) begin
        lfsr_q  <= lfsr_next;
        data_q  <= i_bypass ? s_in.data : y;
        hdr_q   <= s_in.hdr;
        valid_q <= 1'b1;
      end else begin
        if (i_flush) begin
          lfsr_q <= '1;
        end
        if (m_out.ready) begin
          valid_q <= 1'b0;
        end
      end
      lock_cnt_q <= cnt_next;
      locked_q   <= lock_next;
    end
  end

endmodule
